fpu_dispatch_ctrl: RTL and testbench
====================================

Name: fpu_dispatch_ctrl

Overview:
- Sequences the two execution-stage FPU units (fast: add/mul/cvt; slow: div/sqrt).
- Replaces ad-hoc enable-pulse and waiting flops with one FSM. The FSM issues exactly one enable pulse per dispatched instruction, stalls the pipeline until the selected unit responds, and captures the result.
- Holds the result until the execution stage actually advances.
- Sits beside the hazard unit; its fpu_stall feeds stall_f/stall_d/stall_e and flush_m.

Parameters:
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before declaring a unit hung.
- XLEN, 32: result width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- fast_dispatch_e  in  1  fast-FPU instruction in exec stage (level, held while stalled)
- slow_dispatch_e  in  1  slow-FPU instruction in exec stage (level)
- cache_stall  in  1  memory stall; blocks issue
- pipe_stall_e  in  1  exec stage held by any non-FPU stall source
- fast_fpu_valid  in  1  fast unit result valid
- slow_fpu_valid  in  1  slow unit result valid
- fast_fpu_result  in  XLEN  fast unit result
- slow_fpu_result  in  XLEN  slow unit result
- fast_fpu_en_pulse  out  1  one-cycle start to fast unit (registered)
- slow_fpu_en_pulse  out  1  one-cycle start to slow unit (registered)
- fpu_stall  out  1  stall request to hazard logic
- fpu_result_e  out  XLEN  captured result
- fpu_result_valid_e  out  1  result available to exec stage
- busy  out  1  FSM not IDLE
- timeout_err  out  1  sticky hang flag
- dual_dispatch_err  out  1  sticky; both dispatch lines seen high together

Behaviour:
- Reset (async, any state): FSM to IDLE; unit_sel=FAST; all outputs 0; result register 0; counter 0. A late valid arriving after reset is ignored, because IDLE ignores valids.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If (fast|slow dispatch) & ~cache_stall: latch unit_sel and go to ISSUE. Fast wins if both are high; in that case set dual_dispatch_err.
  - If dispatch & cache_stall: stay in IDLE, no pulse.
- ISSUE: the en_pulse of the selected unit is high for exactly this cycle.
  - If the selected valid is also high this cycle: capture, go to DONE.
  - Else go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On the selected valid: capture the result and go to DONE.
  - Valid from the non-selected unit: ignored.
  - When the counter reaches TIMEOUT_CYCLES: set timeout_err, capture 0, go to DONE.
- DONE:
  - fpu_result_valid_e=1 and fpu_stall=0.
  - Stay while pipe_stall_e or cache_stall is high. This prevents re-issue of the same instruction.
  - Otherwise go to IDLE, clear counter.
- fpu_stall = (fast_dispatch_e|slow_dispatch_e) & (state != DONE), combinational. No stall when no dispatch.
- Latency: dispatch seen at cycle 0 → pulse at cycle 1 → unit valid at cycle 1+L → DONE at cycle 2+L, where the stall drops. Minimum total is 2 stall cycles (L=0).
- Dispatch dropping in ISSUE/WAIT (branch flush): finish the current operation, discard the result, go to IDLE after valid or timeout. Result_valid is not asserted.
- The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it never wraps.
- Result register loads only on the capture edge and holds otherwise.

Optional Feature:
- FPU_PERF_CNT_EN defined:
  - Adds 32-bit saturating counters fast_issue_cnt, slow_issue_cnt, fpu_stall_cycles, exposed as output ports.
  - Counters clear on rst.
- FPU_PERF_CNT_EN undefined: counters and ports are absent. Core behaviour is identical.

Decomposition:
- fpu_ctrl_pkg:
  - fpu_state_t enum (IDLE/ISSUE/WAIT/DONE)
  - fpu_unit_t enum (FAST/SLOW)
  - default TIMEOUT_CYCLES constant
- Sub-module fpu_timeout_counter: saturating counter with clear, enable and a terminal-count output.

Test Plan:
- Fast dispatch, fast valid 3 cycles after pulse, result 0x3F800000 → one fast_en_pulse; fpu_stall high 5 cycles; fpu_result_e=0x3F800000 with valid for 1 cycle; busy back to 0.
- Fast dispatch with cache_stall high 4 cycles → no pulse during the stall; pulse on the first cycle after cache_stall falls; exactly one pulse total.
- Slow dispatch, valid never asserted, TIMEOUT_CYCLES=8 → timeout_err set after 8 WAIT cycles; result 0; DONE reached; flag stays set until rst.
- Both dispatch lines high → fast unit pulsed only; dual_dispatch_err=1; slow_fpu_valid ignored.
- DONE with pipe_stall_e high 3 cycles → result held, no second pulse, fpu_stall low; IDLE on the cycle after pipe_stall_e falls.
- rst asserted mid-WAIT, then slow_fpu_valid pulses → all outputs 0 immediately, valid ignored, FSM stays IDLE.

Source files
------------

// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg
// Shared types and defaults for the FPU dispatch controller.
//   fpu_state_t            : controller FSM states
//   fpu_unit_t             : which execution unit an instruction targets
//   DEFAULT_TIMEOUT_CYCLES : default hang-detection limit (WAIT cycles)
//   DEFAULT_XLEN           : default result width
package fpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } fpu_state_t;

    typedef enum logic {
        FAST = 1'b0,
        SLOW = 1'b1
    } fpu_unit_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int DEFAULT_XLEN           = 32;

endpackage

// File: rtl/fpu_timeout_counter.sv
// fpu_timeout_counter
// Saturating up-counter used to bound how long the controller waits on a unit.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count this cycle
//   tc       : terminal count; high on the enabled cycle whose increment
//              reaches LIMIT (or once already saturated), so the caller sees
//              exactly LIMIT enabled cycles before tc acts
module fpu_timeout_counter #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);
    localparam logic [W-1:0] LAST_V  = W'(LIMIT - 1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != LIMIT_V)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign tc = en && (count_q >= LAST_V);

endmodule

// File: rtl/fpu_dispatch_ctrl.sv
// fpu_dispatch_ctrl
// Issues one start pulse per FPU instruction in the execution stage, stalls
// the pipeline until the selected unit answers (or is declared hung), and
// holds the captured result until the execution stage advances.
// Optional build macro: FPU_PERF_CNT_EN adds saturating performance counters
// (fast_issue_cnt, slow_issue_cnt, fpu_stall_cycles) as extra output ports.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   fast_dispatch_e, slow_dispatch_e  : FPU instruction present in exec (level)
//   cache_stall                       : memory stall, blocks issue / holds DONE
//   pipe_stall_e                      : exec held by a non-FPU stall source
//   fast_fpu_valid, slow_fpu_valid    : unit result valid
//   fast_fpu_result, slow_fpu_result  : unit results
//   fast_fpu_en_pulse, slow_fpu_en_pulse : registered one-cycle unit starts
//   fpu_stall                         : stall request to hazard logic
//   fpu_result_e, fpu_result_valid_e  : captured result and its valid
//   busy                              : controller not idle
//   timeout_err, dual_dispatch_err    : sticky error flags
//
// state | meaning
// IDLE  | no operation in flight; waits for a dispatch without cache stall
// ISSUE | start pulse to the selected unit is high this cycle
// WAIT  | waiting for the selected unit's valid, bounded by timeout
// DONE  | result presented to exec; held until exec advances
module fpu_dispatch_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int XLEN           = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fast_dispatch_e,
    input  logic            slow_dispatch_e,
    input  logic            cache_stall,
    input  logic            pipe_stall_e,
    input  logic            fast_fpu_valid,
    input  logic            slow_fpu_valid,
    input  logic [XLEN-1:0] fast_fpu_result,
    input  logic [XLEN-1:0] slow_fpu_result,
    output logic            fast_fpu_en_pulse,
    output logic            slow_fpu_en_pulse,
    output logic            fpu_stall,
    output logic [XLEN-1:0] fpu_result_e,
    output logic            fpu_result_valid_e,
    output logic            busy,
    output logic            timeout_err,
    output logic            dual_dispatch_err
`ifdef FPU_PERF_CNT_EN
    ,
    output logic [31:0]     fast_issue_cnt,
    output logic [31:0]     slow_issue_cnt,
    output logic [31:0]     fpu_stall_cycles
`endif
);

    fpu_state_t      state_q, state_d;
    fpu_unit_t       unit_q, unit_d;
    logic            flushed_q, flushed_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            result_load;
    logic            fast_pulse_q, slow_pulse_q;
    logic            timeout_q, timeout_set;
    logic            dual_q, dual_set;
    logic            dispatch_any;
    logic            sel_valid;
    logic [XLEN-1:0] sel_result;
    logic            discard;
    logic            cnt_clr, cnt_en, cnt_tc;

    assign dispatch_any = fast_dispatch_e | slow_dispatch_e;
    assign sel_valid    = (unit_q == FAST) ? fast_fpu_valid  : slow_fpu_valid;
    assign sel_result   = (unit_q == FAST) ? fast_fpu_result : slow_fpu_result;
    // Dispatch dropping mid-operation means the instruction was flushed; the
    // unit still has to finish, but its answer must not reach exec.
    assign discard      = flushed_q | ~dispatch_any;

    assign cnt_clr = (state_q == IDLE);
    assign cnt_en  = (state_q == WAIT);

    fpu_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            unit_q       <= FAST;
            flushed_q    <= 1'b0;
            result_q     <= '0;
            fast_pulse_q <= 1'b0;
            slow_pulse_q <= 1'b0;
            timeout_q    <= 1'b0;
            dual_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            unit_q       <= unit_d;
            flushed_q    <= flushed_d;
            if (result_load) begin
                result_q <= result_d;
            end
            // ISSUE is only entered from IDLE, so this is one pulse per issue.
            fast_pulse_q <= (state_d == ISSUE) && (unit_d == FAST);
            slow_pulse_q <= (state_d == ISSUE) && (unit_d == SLOW);
            timeout_q    <= timeout_q | timeout_set;
            dual_q       <= dual_q | dual_set;
        end
    end

    always_comb begin
        state_d     = state_q;
        unit_d      = unit_q;
        flushed_d   = flushed_q;
        result_load = 1'b0;
        result_d    = '0;
        timeout_set = 1'b0;
        dual_set    = 1'b0;
        case (state_q)
            IDLE: begin
                flushed_d = 1'b0;
                if (dispatch_any && !cache_stall) begin
                    unit_d   = fast_dispatch_e ? FAST : SLOW;
                    dual_set = fast_dispatch_e & slow_dispatch_e;
                    state_d  = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                flushed_d = discard;
                // A real answer wins over a timeout landing on the same cycle.
                if (sel_valid) begin
                    result_load = ~discard;
                    result_d    = sel_result;
                    state_d     = discard ? IDLE : DONE;
                end else if ((state_q == WAIT) && cnt_tc) begin
                    timeout_set = 1'b1;
                    result_load = ~discard;
                    result_d    = '0;
                    state_d     = discard ? IDLE : DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (!pipe_stall_e && !cache_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fast_fpu_en_pulse  = fast_pulse_q;
    assign slow_fpu_en_pulse  = slow_pulse_q;
    assign fpu_stall          = dispatch_any && (state_q != DONE);
    assign fpu_result_e       = result_q;
    assign fpu_result_valid_e = (state_q == DONE);
    assign busy               = (state_q != IDLE);
    assign timeout_err        = timeout_q;
    assign dual_dispatch_err  = dual_q;

`ifdef FPU_PERF_CNT_EN
    logic [31:0] fast_cnt_q, slow_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fast_cnt_q  <= '0;
            slow_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fast_pulse_q && (fast_cnt_q != '1)) begin
                fast_cnt_q <= fast_cnt_q + 32'd1;
            end
            if (slow_pulse_q && (slow_cnt_q != '1)) begin
                slow_cnt_q <= slow_cnt_q + 32'd1;
            end
            if (fpu_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fast_issue_cnt   = fast_cnt_q;
    assign slow_issue_cnt   = slow_cnt_q;
    assign fpu_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_dispatch_ctrl.sv
// tb_fpu_dispatch_ctrl
// Transaction-level bench: each instruction is described by unit, response
// latency, cache-stall cycles before issue, exec-hold cycles in DONE and an
// optional flush point. Expected pulse cycle, stall length, result-valid
// length, result value and sticky flags come from the latency arithmetic of
// the dispatch protocol (pulse at cstall+1, result at pulse+1+min(L,T)).
module tb_fpu_dispatch_ctrl;
    localparam int T    = 8;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            fast_dispatch_e, slow_dispatch_e, cache_stall, pipe_stall_e;
    logic            fast_fpu_valid, slow_fpu_valid;
    logic [XLEN-1:0] fast_fpu_result, slow_fpu_result;
    logic            fast_fpu_en_pulse, slow_fpu_en_pulse, fpu_stall;
    logic [XLEN-1:0] fpu_result_e;
    logic            fpu_result_valid_e, busy, timeout_err, dual_dispatch_err;
`ifdef FPU_PERF_CNT_EN
    logic [31:0]     fast_issue_cnt, slow_issue_cnt, fpu_stall_cycles;
`endif

    fpu_dispatch_ctrl #(.TIMEOUT_CYCLES(T), .XLEN(XLEN)) dut (
        .clk                (clk),
        .rst                (rst),
        .fast_dispatch_e    (fast_dispatch_e),
        .slow_dispatch_e    (slow_dispatch_e),
        .cache_stall        (cache_stall),
        .pipe_stall_e       (pipe_stall_e),
        .fast_fpu_valid     (fast_fpu_valid),
        .slow_fpu_valid     (slow_fpu_valid),
        .fast_fpu_result    (fast_fpu_result),
        .slow_fpu_result    (slow_fpu_result),
        .fast_fpu_en_pulse  (fast_fpu_en_pulse),
        .slow_fpu_en_pulse  (slow_fpu_en_pulse),
        .fpu_stall          (fpu_stall),
        .fpu_result_e       (fpu_result_e),
        .fpu_result_valid_e (fpu_result_valid_e),
        .busy               (busy),
        .timeout_err        (timeout_err),
        .dual_dispatch_err  (dual_dispatch_err)
`ifdef FPU_PERF_CNT_EN
        ,
        .fast_issue_cnt     (fast_issue_cnt),
        .slow_issue_cnt     (slow_issue_cnt),
        .fpu_stall_cycles   (fpu_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic            exp_timeout = 1'b0;
    logic            exp_dual    = 1'b0;
    logic [XLEN-1:0] last_result = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        fast_dispatch_e = 1'b0;
        slow_dispatch_e = 1'b0;
        cache_stall     = 1'b0;
        pipe_stall_e    = 1'b0;
        fast_fpu_valid  = 1'b0;
        slow_fpu_valid  = 1'b0;
        fast_fpu_result = '0;
        slow_fpu_result = '0;
    endtask

    // lat > T models a unit that never answers.
    task automatic run_txn(input bit is_slow, input bit dual, input int lat,
                           input int cstall, input int pstall,
                           input logic [XLEN-1:0] value,
                           input bit flush, input int fofs);
        bit              eff_slow = dual ? 1'b0 : is_slow;
        int              eff_lat  = (lat > T) ? T : lat;
        int              p_cyc    = cstall + 1;
        int              d_cyc    = p_cyc + 1 + eff_lat;
        int              f_cyc    = p_cyc + fofs;
        int              e_cyc    = flush ? d_cyc : d_cyc + pstall + 1;
        logic [XLEN-1:0] exp_res  = (lat <= T) ? value : '0;
        int              nfast = 0, nslow = 0, nstall = 0, nvalid = 0, nbad = 0;
        int              pf = -1, ps = -1;
        logic            busy_pre = 1'b0, busy_end = 1'b1;
        logic [XLEN-1:0] res_end = '0;
        for (int c = 0; c <= e_cyc; c++) begin
            bit disp    = flush ? (c < f_cyc) : (c < e_cyc);
            bit in_hold = !flush && (c >= d_cyc) && (c < d_cyc + pstall);
            bit src     = 1'($urandom_range(0, 1));
            bit hit     = (lat <= T) && (c == p_cyc + lat);
            bit noise_o = (c >= p_cyc && c < d_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
            bit noise_s = (c < p_cyc || c >= d_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
            fast_dispatch_e = disp && (dual || !eff_slow);
            slow_dispatch_e = disp && (dual || eff_slow);
            cache_stall     = (c < cstall) || (in_hold && src);
            pipe_stall_e    = in_hold ? !src : ((c < d_cyc) ? 1'($urandom_range(0, 1)) : 1'b0);
            if (eff_slow) begin
                slow_fpu_valid  = hit || noise_s;
                slow_fpu_result = hit ? value : $urandom;
                fast_fpu_valid  = noise_o;
                fast_fpu_result = $urandom;
            end else begin
                fast_fpu_valid  = hit || noise_s;
                fast_fpu_result = hit ? value : $urandom;
                slow_fpu_valid  = noise_o;
                slow_fpu_result = $urandom;
            end
            @(negedge clk);
            if (fast_fpu_en_pulse) begin nfast++; if (pf < 0) pf = c; end
            if (slow_fpu_en_pulse) begin nslow++; if (ps < 0) ps = c; end
            if (fpu_stall) nstall++;
            if (fpu_result_valid_e) begin
                nvalid++;
                if (fpu_result_e !== exp_res) nbad++;
            end
            if (c == d_cyc - 1) busy_pre = busy;
            if (c == e_cyc) begin busy_end = busy; res_end = fpu_result_e; end
            @(posedge clk);
            #1;
        end
        idle_inputs();
        if (!flush) last_result = exp_res;
        exp_timeout = exp_timeout | (lat > T);
        exp_dual    = exp_dual | dual;
        check_val("sel_pulses",   eff_slow ? nslow : nfast, 1);
        check_val("other_pulses", eff_slow ? nfast : nslow, 0);
        check_val("pulse_cycle",  eff_slow ? ps : pf, p_cyc);
        check_val("stall_cycles", nstall, flush ? f_cyc : d_cyc);
        check_val("valid_cycles", nvalid, flush ? 0 : pstall + 1);
        check_val("result_bad_cycles", nbad, 0);
        check_val("result_reg",   res_end, last_result);
        check_val("busy_pre",     busy_pre, 1);
        check_val("busy_end",     busy_end, 0);
        check_val("timeout_err",  timeout_err, exp_timeout);
        check_val("dual_err",     dual_dispatch_err, exp_dual);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_fast_pulse"}, fast_fpu_en_pulse, 0);
        check_val({tag, "_slow_pulse"}, slow_fpu_en_pulse, 0);
        check_val({tag, "_stall"},      fpu_stall, 0);
        check_val({tag, "_result"},     fpu_result_e, 0);
        check_val({tag, "_rvalid"},     fpu_result_valid_e, 0);
        check_val({tag, "_busy"},       busy, 0);
        check_val({tag, "_timeout"},    timeout_err, 0);
        check_val({tag, "_dual"},       dual_dispatch_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases from the plan.
        run_txn(0, 0, 3,     0, 0, 32'h3F80_0000, 0, 0);   // fast, L=3 -> 5 stall cycles
        run_txn(0, 0, 1,     4, 0, 32'h4000_0000, 0, 0);   // cache stall blocks issue
        run_txn(1, 0, T + 5, 0, 1, 32'h1234_5678, 0, 0);   // slow timeout
        run_txn(1, 1, 2,     0, 0, 32'h4040_0000, 0, 0);   // dual dispatch -> fast
        run_txn(0, 0, 0,     0, 3, 32'h4080_0000, 0, 0);   // DONE held by pipe stall
        run_txn(1, 0, T,     0, 0, 32'hCAFE_0001, 0, 0);   // valid on the timeout cycle
        run_txn(1, 0, 4,     1, 0, 32'hBAD0_BAD0, 1, 2);   // flush mid-WAIT

        for (int i = 0; i < 60; i++) begin
            bit is_slow = 1'($urandom_range(0, 1));
            bit dual    = ($urandom_range(0, 7) == 0);
            int lat     = $urandom_range(0, T + 3);
            int eff     = (lat > T) ? T : lat;
            bit flush   = ($urandom_range(0, 5) == 0);
            run_txn(is_slow, dual, lat, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom, flush, $urandom_range(0, eff));
        end

        // Reset in the middle of WAIT, then a late valid.
        slow_dispatch_e = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_val("busy_before_rst", busy, 1);
        rst = 1'b1;
        slow_dispatch_e = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_timeout = 1'b0;
        exp_dual    = 1'b0;
        last_result = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        slow_fpu_valid  = 1'b1;
        slow_fpu_result = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        slow_fpu_valid  = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("late_valid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
